// File: rtl/adc_ltc2308_pkg.sv
// Shared types, constants and helpers for the LTC2308 round-robin scanner.
// Holds the FSM state enum, the command-word builder and the channel-mask helpers.
package adc_ltc2308_pkg;

    localparam int DATA_BITS = 12;
    localparam int CMD_BITS  = 6;
    localparam int NUM_CH    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVST,
        ST_CONV,
        ST_XFER,
        ST_ACQ
    } state_e;

    // Command bits: S/D=1 (single-ended), O/S, S1, S0, UNI, SLP=0
    function automatic logic [CMD_BITS-1:0] build_cmd(logic [2:0] ch, logic uni);
        return {1'b1, ch[0], ch[2:1], uni, 1'b0};
    endfunction

    function automatic logic [NUM_CH-1:0] eff_mask(logic [NUM_CH-1:0] mask);
        return (mask == '0) ? 8'h01 : mask;
    endfunction

    function automatic logic [2:0] lowest_ch(logic [NUM_CH-1:0] mask);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [2:0] highest_ch(logic [NUM_CH-1:0] mask);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Smallest set channel above ch, wrapping to the lowest set channel
    function automatic logic [2:0] next_ch(logic [NUM_CH-1:0] mask, logic [2:0] ch);
        logic [2:0] r;
        r = lowest_ch(mask);
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(ch))) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_ltc2308_scan_if.sv
// Bundle of the scanner's sample stream, enable and LTC2308 pins.
// master = scanner side, slave = consumer/ADC side.
interface adc_ltc2308_scan_if;
    logic        enable;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data;
    logic        scan_done;
    logic        ADC_CONVST;
    logic        ADC_SCK;
    logic        ADC_SDI;
    logic        ADC_SDO;

    modport master (
        input  enable, ADC_SDO,
        output sample_valid, sample_ch, sample_data, scan_done,
        output ADC_CONVST, ADC_SCK, ADC_SDI
    );

    modport slave (
        output enable, ADC_SDO,
        input  sample_valid, sample_ch, sample_data, scan_done,
        input  ADC_CONVST, ADC_SCK, ADC_SDI
    );
endinterface

// File: rtl/adc_ltc2308_sclk_gen.sv
// Registered SCK divider: toggles every CLK_DIV clocks while run is high, idles low,
// and provides rise/fall strobes one clock ahead of the pin edge plus a rise count.
module adc_ltc2308_sclk_gen
    import adc_ltc2308_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    output logic       sck,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       sck_done,
    output logic [3:0] bit_cnt
);

    logic [7:0] div_q, div_d;
    logic       sck_q, sck_d;
    logic [3:0] bit_q, bit_d;
    logic       toggle;

    always_comb begin
        toggle   = run && (div_q == 8'(CLK_DIV - 1));
        sck_rise = toggle && !sck_q;
        sck_fall = toggle && sck_q;
        sck_done = sck_fall && (bit_q == 4'(DATA_BITS));
        div_d    = '0;
        sck_d    = 1'b0;
        bit_d    = '0;
        if (run) begin
            div_d = toggle ? 8'd0 : div_q + 8'd1;
            sck_d = sck_q ^ toggle;
            bit_d = bit_q + {3'b000, sck_rise};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            sck_q <= 1'b0;
            bit_q <= '0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
            bit_q <= bit_d;
        end
    end

    assign sck     = sck_q;
    assign bit_cnt = bit_q;

endmodule

// File: rtl/adc_ltc2308_scan.sv
// LTC2308 round-robin channel scanner with one-frame command pipelining.
// Optional ADC_SCAN_AVG_EN: four conversions per channel averaged into one sample.
module adc_ltc2308_scan
    import adc_ltc2308_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned T_CONV   = 64,
    parameter int unsigned T_ACQ    = 12,
    parameter logic [7:0]  CH_MASK  = 8'hFF,
    parameter bit          UNIPOLAR = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    adc_ltc2308_scan_if.master bus
);

    localparam logic [7:0] MASK     = eff_mask(CH_MASK);
    localparam logic [2:0] FIRST_CH = lowest_ch(MASK);
    localparam logic [2:0] LAST_CH  = highest_ch(MASK);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  ch_q, ch_d, pend_ch_q, pend_ch_d, samp_ch_q, samp_ch_d;
    logic        pend_vld_q, pend_vld_d;
    logic [11:0] shift_q, shift_d, samp_data_q, samp_data_d;
    logic        convst_q, convst_d, sdi_q, sdi_d;
    logic        valid_q, valid_d, done_q, done_d;
    logic        sck, sck_rise, sck_fall, sck_done;
    logic [3:0]  bit_cnt;
    logic [5:0]  cmd;
    logic [11:0] captured, result;
    logic        retire;
`ifdef ADC_SCAN_AVG_EN
    logic [1:0]  rep_q, rep_d, pend_rep_q, pend_rep_d;
    logic [13:0] acc_q, acc_d, sum;
`endif

    adc_ltc2308_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (state_q == ST_XFER),
        .sck      (sck),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .sck_done (sck_done),
        .bit_cnt  (bit_cnt)
    );

    always_comb begin
        cmd         = build_cmd(ch_q, UNIPOLAR);
        captured    = {shift_q[10:0], bus.ADC_SDO};
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        ch_d        = ch_q;
        pend_ch_d   = pend_ch_q;
        pend_vld_d  = pend_vld_q;
        shift_d     = shift_q;
        sdi_d       = 1'b0;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        samp_ch_d   = samp_ch_q;
        samp_data_d = samp_data_q;
        retire      = 1'b0;
        result      = captured;
`ifdef ADC_SCAN_AVG_EN
        rep_d       = rep_q;
        pend_rep_d  = pend_rep_q;
        acc_d       = acc_q;
        sum         = ((pend_rep_q == 2'd0) ? 14'd0 : acc_q) + {2'b00, captured};
        result      = sum[13:2];
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.enable) state_d = ST_CONVST;
            end
            ST_CONVST: if (cnt_q == 16'd1) begin
                state_d = ST_CONV;
                cnt_d   = '0;
            end
            ST_CONV: if (cnt_q == 16'(T_CONV - 1)) begin
                state_d = ST_XFER;
                cnt_d   = '0;
                sdi_d   = cmd[5];
            end
            ST_XFER: begin
                cnt_d = '0;
                sdi_d = sdi_q;
                if (sck_fall)
                    sdi_d = (bit_cnt < 4'(CMD_BITS)) ? cmd[3'(4'd5 - bit_cnt)] : 1'b0;
                if (sck_rise) shift_d = captured;
                // The 12th rising edge completes the word converted under last frame's command
                if (sck_rise && (bit_cnt == 4'(DATA_BITS - 1)) && pend_vld_q) begin
`ifdef ADC_SCAN_AVG_EN
                    acc_d  = sum;
                    retire = (pend_rep_q == 2'd3);
`else
                    retire = 1'b1;
`endif
                end
                if (sck_done) begin
                    state_d    = ST_ACQ;
                    pend_ch_d  = ch_q;
                    pend_vld_d = 1'b1;
`ifdef ADC_SCAN_AVG_EN
                    pend_rep_d = rep_q;
                    rep_d      = rep_q + 2'd1;
                    if (rep_q == 2'd3) ch_d = next_ch(MASK, ch_q);
`else
                    ch_d       = next_ch(MASK, ch_q);
`endif
                end
            end
            ST_ACQ: if (cnt_q == 16'(T_ACQ - 1)) begin
                cnt_d = '0;
                if (bus.enable) begin
                    state_d = ST_CONVST;
                end else begin
                    state_d    = ST_IDLE;
                    ch_d       = FIRST_CH;
                    pend_vld_d = 1'b0;
`ifdef ADC_SCAN_AVG_EN
                    rep_d      = 2'd0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (retire) begin
            valid_d     = 1'b1;
            samp_ch_d   = pend_ch_q;
            samp_data_d = result;
            done_d      = (pend_ch_q == LAST_CH);
        end
        convst_d = (state_d == ST_CONVST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ch_q        <= FIRST_CH;
            pend_ch_q   <= FIRST_CH;
            pend_vld_q  <= 1'b0;
            shift_q     <= '0;
            convst_q    <= 1'b0;
            sdi_q       <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            samp_ch_q   <= '0;
            samp_data_q <= '0;
`ifdef ADC_SCAN_AVG_EN
            rep_q       <= '0;
            pend_rep_q  <= '0;
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            pend_ch_q   <= pend_ch_d;
            pend_vld_q  <= pend_vld_d;
            shift_q     <= shift_d;
            convst_q    <= convst_d;
            sdi_q       <= sdi_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            samp_ch_q   <= samp_ch_d;
            samp_data_q <= samp_data_d;
`ifdef ADC_SCAN_AVG_EN
            rep_q       <= rep_d;
            pend_rep_q  <= pend_rep_d;
            acc_q       <= acc_d;
`endif
        end
    end

    assign bus.ADC_CONVST   = convst_q;
    assign bus.ADC_SCK      = sck;
    assign bus.ADC_SDI      = sdi_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_ch    = samp_ch_q;
    assign bus.sample_data  = samp_data_q;
    assign bus.scan_done    = done_q;

endmodule

// File: tb/tb_adc_ltc2308_scan.sv
// Directed bench for adc_ltc2308_scan with a cycle-level LTC2308 model per instance.
// Build with ADC_SCAN_AVG_EN defined to exercise the averaging variant.
module tb_adc_ltc2308_scan;

    logic clk = 1'b0;
    logic rst_g, rstn0;
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_ltc2308_scan_if if0 ();
    adc_ltc2308_scan_if if1 ();
    adc_ltc2308_scan_if if2 ();

    adc_ltc2308_scan #(.CLK_DIV(2), .CH_MASK(8'h05)) dut0 (.clk(clk), .reset_n(rstn0), .bus(if0));
    adc_ltc2308_scan #(.CLK_DIV(1), .T_CONV(64), .T_ACQ(12), .CH_MASK(8'h80)) dut1 (.clk(clk), .reset_n(rst_g), .bus(if1));
    adc_ltc2308_scan #(.CLK_DIV(1), .CH_MASK(8'h02)) dut2 (.clk(clk), .reset_n(rst_g), .bus(if2));

    logic        cv [3], sk [3], sd [3], vl [3], dn [3];
    logic [2:0]  sch [3];
    logic [11:0] sdat [3];
    logic        so [3] = '{1'b0, 1'b0, 1'b0};

    assign cv[0] = if0.ADC_CONVST; assign cv[1] = if1.ADC_CONVST; assign cv[2] = if2.ADC_CONVST;
    assign sk[0] = if0.ADC_SCK;    assign sk[1] = if1.ADC_SCK;    assign sk[2] = if2.ADC_SCK;
    assign sd[0] = if0.ADC_SDI;    assign sd[1] = if1.ADC_SDI;    assign sd[2] = if2.ADC_SDI;
    assign vl[0] = if0.sample_valid; assign vl[1] = if1.sample_valid; assign vl[2] = if2.sample_valid;
    assign dn[0] = if0.scan_done;  assign dn[1] = if1.scan_done;  assign dn[2] = if2.scan_done;
    assign sch[0] = if0.sample_ch; assign sch[1] = if1.sample_ch; assign sch[2] = if2.sample_ch;
    assign sdat[0] = if0.sample_data; assign sdat[1] = if1.sample_data; assign sdat[2] = if2.sample_data;
    assign if0.ADC_SDO = so[0];
    assign if1.ADC_SDO = so[1];
    assign if2.ADC_SDO = so[2];

    // ADC model state: command received last frame selects this frame's conversion
    logic [5:0]  rx_cmd [3] = '{6'b100010, 6'b100010, 6'b100010};
    logic [5:0]  rx_sh  [3] = '{6'd0, 6'd0, 6'd0};
    int          rx_bits[3] = '{0, 0, 0};
    int          conv_n [3] = '{0, 0, 0};
    logic [11:0] res    [3] = '{12'd0, 12'd0, 12'd0};
    logic [11:0] shr    [3] = '{12'd0, 12'd0, 12'd0};
    logic        pcv    [3] = '{1'b0, 1'b0, 1'b0};
    logic        psk    [3] = '{1'b0, 1'b0, 1'b0};

    function automatic logic [11:0] model_val(int g, logic [5:0] cmd, int n);
        logic [2:0] ch;
        ch = {cmd[3:2], cmd[4]};
        if (g == 0) return 12'(int'(ch) * 100);
        if (g == 1) return 12'hABC;
        case ((n - 2) & 3)
            0:       return 12'd100;
            1:       return 12'd101;
            2:       return 12'd102;
            default: return 12'd104;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (cv[g] && !pcv[g]) begin
                conv_n[g]  <= conv_n[g] + 1;
                res[g]     <= model_val(g, rx_cmd[g], conv_n[g] + 1);
                rx_bits[g] <= 0;
            end
            if (!cv[g] && pcv[g]) begin
                shr[g] <= res[g];
                so[g]  <= res[g][11];
            end
            if (sk[g] && !psk[g]) begin
                rx_sh[g]   <= {rx_sh[g][4:0], sd[g]};
                rx_bits[g] <= rx_bits[g] + 1;
                if (rx_bits[g] == 5) rx_cmd[g] <= {rx_sh[g][4:0], sd[g]};
            end
            if (!sk[g] && psk[g]) begin
                shr[g] <= shr[g] << 1;
                so[g]  <= shr[g][10];
            end
            pcv[g] <= cv[g];
            psk[g] <= sk[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int g, input int budget, output logic [2:0] ch,
                              output logic [11:0] d, output logic done, output int waited);
        logic seen;
        seen = 1'b0; ch = 'x; d = 'x; done = 1'bx; waited = 0;
        while (waited < budget && !seen) begin
            @(posedge clk); #1;
            waited++;
            if (vl[g]) begin
                seen = 1'b1; ch = sch[g]; d = sdat[g]; done = dn[g];
            end
        end
        chk("valid_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_edge(input int g, input bit on_sck, input bit rising, input int budget, output int t);
        logic prev, cur;
        prev = on_sck ? sk[g] : cv[g];
        t = -1;
        for (int n = 0; n < budget && t < 0; n++) begin
            @(posedge clk); #1;
            cur = on_sck ? sk[g] : cv[g];
            if (cur == rising && prev != rising) t = cyc;
            prev = cur;
        end
        if (t < 0) chk("edge_timeout", 32'(t), 32'd0);
    endtask

    task automatic count_ev(input int g, input bit on_valid, input int cycles, output int cnt);
        logic prev;
        prev = cv[g];
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            if (on_valid) begin
                if (vl[g]) cnt++;
            end else if (cv[g] && !prev) begin
                cnt++;
            end
            prev = cv[g];
        end
    endtask

    logic [2:0]  c;
    logic [11:0] d;
    logic        f;
    int          w, t0, t1, t2, n;
    logic [11:0] avg_exp;

    initial begin
        rst_g = 1'b0; rstn0 = 1'b0;
        if0.enable = 1'b0; if1.enable = 1'b0; if2.enable = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_convst", 32'(if0.ADC_CONVST), 0);
        chk("rst_sck", 32'(if0.ADC_SCK), 0);
        chk("rst_sdi", 32'(if0.ADC_SDI), 0);
        chk("rst_valid", 32'(if0.sample_valid), 0);
        chk("rst_done", 32'(if0.scan_done), 0);
        chk("rst_ch", 32'(if0.sample_ch), 0);
        chk("rst_data", 32'(if0.sample_data), 0);
        chk("rst_data1", 32'(if1.sample_data), 0);
        @(negedge clk); rst_g = 1'b1; rstn0 = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("idle_convst", 32'(if0.ADC_CONVST), 0);

        // CH_MASK=05, ADC returns ch*100
        if0.enable = 1'b1;
        wait_valid(0, 400, c, d, f, w);
        chk("dummy_skipped", 32'(w > 126), 1);
        chk("s1_ch", 32'(c), 0); chk("s1_data", 32'(d), 0); chk("s1_done", 32'(f), 0);
        wait_valid(0, 200, c, d, f, w);
        chk("s2_ch", 32'(c), 2); chk("s2_data", 32'(d), 200); chk("s2_done", 32'(f), 1);
        @(posedge clk); #1;
        chk("hold_valid", 32'(if0.sample_valid), 0);
        chk("hold_ch", 32'(if0.sample_ch), 2);
        chk("hold_data", 32'(if0.sample_data), 200);
        wait_valid(0, 200, c, d, f, w);
        chk("s3_ch", 32'(c), 0); chk("s3_data", 32'(d), 0); chk("s3_done", 32'(f), 0);

        // Drop enable at the 5th SCK of the next frame
        wait_edge(0, 1'b0, 1'b0, 200, t0);
        repeat (5) wait_edge(0, 1'b1, 1'b1, 200, t0);
        if0.enable = 1'b0;
        wait_valid(0, 200, c, d, f, w);
        chk("drop_ch", 32'(c), 2); chk("drop_data", 32'(d), 200); chk("drop_done", 32'(f), 1);
        count_ev(0, 1'b0, 400, n);
        chk("idle_no_convst", 32'(n), 0);
        chk("idle_convst_low", 32'(if0.ADC_CONVST), 0);
        if0.enable = 1'b1;
        wait_valid(0, 400, c, d, f, w);
        chk("reen_dummy", 32'(w > 126), 1);
        chk("reen_ch", 32'(c), 0); chk("reen_data", 32'(d), 0);
        wait_valid(0, 200, c, d, f, w);
        chk("reen2_ch", 32'(c), 2); chk("reen2_data", 32'(d), 200);

        // Reset pulse mid-transfer
        wait_edge(0, 1'b0, 1'b0, 200, t0);
        repeat (3) wait_edge(0, 1'b1, 1'b1, 200, t0);
        #2 rstn0 = 1'b0;
        #1;
        chk("mid_rst_convst", 32'(if0.ADC_CONVST), 0);
        chk("mid_rst_sck", 32'(if0.ADC_SCK), 0);
        chk("mid_rst_sdi", 32'(if0.ADC_SDI), 0);
        chk("mid_rst_valid", 32'(if0.sample_valid), 0);
        chk("mid_rst_done", 32'(if0.scan_done), 0);
        chk("mid_rst_ch", 32'(if0.sample_ch), 0);
        chk("mid_rst_data", 32'(if0.sample_data), 0);
        repeat (3) @(negedge clk);
        rstn0 = 1'b1;
        count_ev(0, 1'b1, 200, n);
        chk("post_rst_no_valid", 32'(n), 0);
        wait_valid(0, 300, c, d, f, w);
        chk("post_rst_ch", 32'(c), 0); chk("post_rst_data", 32'(d), 0);
        if0.enable = 1'b0;

        // CH_MASK=80, CLK_DIV=1, ADC returns 0xABC
        if1.enable = 1'b1;
        wait_edge(1, 1'b0, 1'b1, 50, t0);
        wait_edge(1, 1'b0, 1'b1, 200, t1);
        wait_edge(1, 1'b0, 1'b1, 200, t2);
        chk("convst_period1", 32'(t1 - t0), 102);
        chk("convst_period2", 32'(t2 - t1), 102);
        wait_valid(1, 200, c, d, f, w);
        chk("m80_ch", 32'(c), 7); chk("m80_data", 32'(d), 32'hABC); chk("m80_done", 32'(f), 1);
        chk("m80_sdi_cmd", 32'(rx_cmd[1]), 32'b111110);
        wait_valid(1, 200, c, d, f, w);
        chk("m80_data2", 32'(d), 32'hABC); chk("m80_ch2", 32'(c), 7);
        if1.enable = 1'b0;

        // CH_MASK=02, ADC returns 100,101,102,104 in turn
`ifdef ADC_SCAN_AVG_EN
        avg_exp = 12'd101;
`else
        avg_exp = 12'd100;
`endif
        if2.enable = 1'b1;
        wait_valid(2, 1000, c, d, f, w);
        chk("m02_data", 32'(d), 32'(avg_exp));
        chk("m02_ch", 32'(c), 1);
        chk("m02_done", 32'(f), 1);
        if2.enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
